ternary_bin2bt_conv: RTL and testbench
======================================

TERNARY_BIN2BT_CONV -- requirements
Module: ternary_bin2bt_conv

Interface
REQ-001 Parameter WIDTH, default 8, number of output trits.
REQ-002 Parameter BIN_W, default 16, width of the signed two's-complement binary input.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  the block can accept a value; high only in IDLE with rst low.
REQ-007 in_data  input  BIN_W  signed binary value to convert.
REQ-008 out_valid  output  1  out_trits and out_ovf hold a completed result.
REQ-009 out_ready  input  1  the consumer accepts the result.
REQ-010 out_trits  output  trit_t[WIDTH-1:0]  balanced-ternary result; index 0 is the least significant trit.
REQ-011 out_ovf  output  1  the input value lies outside +/-(3^WIDTH-1)/2.

Function
REQ-012 The FSM shall have three states: IDLE, CONV and DONE.
REQ-013 IDLE: the input handshake (in_valid && in_ready) shall load the residue register (BIN_W+1 bits, sign-extended from in_data), clear the trit index, and move to CONV.
REQ-014 CONV: each cycle shall produce exactly one trit, LSB first, at the current index:
 - r = floor-mod(residue, 3), with r in {0,1,2}
 - r=0 gives T_ZERO, r=1 gives T_POS_ONE, r=2 gives T_NEG_ONE
 - residue_next = (residue - digit)/3, which is an exact division
REQ-015 After the WIDTH-th trit, the FSM shall move to DONE and set out_ovf = (final residue != 0).
REQ-016 Latency shall be fixed: handshake in cycle k gives out_valid high in cycle k+WIDTH+1, independent of the value, with no early exit.
REQ-017 DONE: out_valid shall be high; out_trits and out_ovf shall stay stable until the handshake (out_valid && out_ready), after which the FSM returns to IDLE and in_ready is high the next cycle.
REQ-018 in_valid outside IDLE shall be ignored: no load, no state change.
REQ-019 On overflow, out_trits shall hold the WIDTH low-order balanced trits of the input, i.e. the input minus (carry x 3^WIDTH).
REQ-020 out_trits shall never carry T_INVALID.
REQ-021 Trits not yet written during CONV shall keep T_ZERO from the load; out_trits is undefined for consumers while out_valid is low.

Reset
REQ-022 While rst is high at a clock edge, the next state shall be:
 - state = IDLE
 - out_valid = 0, in_ready = 0
 - out_ovf = 0, out_trits all T_ZERO
 - residue and index cleared
REQ-023 rst shall override every other input in any state, including mid-CONV and DONE with out_ready low; any partial result shall be discarded.
REQ-024 The first accept shall be possible in the first cycle after rst deasserts.

Structure
REQ-025 trit_t and T_NEG_ONE, T_ZERO, T_POS_ONE and T_INVALID shall come from ternary_pkg; the FSM state enum shall be added to ternary_pkg as conv_state_t.
REQ-026 The per-cycle digit step (residue in, trit plus next residue out, purely combinational) shall be a single sub-module, ternary_bt_digit.
REQ-027 Division by 3 shall be by constant, with no generic divider.

Verification
REQ-028 Input 0 -> out_trits all T_ZERO, out_ovf=0, out_valid exactly WIDTH+1=9 cycles after accept.
REQ-029 Input 10 -> [0]=+1, [1]=0, [2]=+1, rest 0; input -5 -> [0]=+1, [1]=+1, [2]=-1, rest 0; both with out_ovf=0.
REQ-030 Input 3280 -> all trits +1, out_ovf=0; input 3281 -> all trits -1, out_ovf=1; input -32768 -> out_ovf=1.
REQ-031 Backpressure: out_ready low for 5 cycles in DONE -> out_trits and out_valid stable, in_ready=0, a pulsed in_valid=1 with in_data=7 is ignored; the result after release is still the original value.
REQ-032 rst pulsed in the 3rd CONV cycle -> next cycle IDLE, out_valid=0, in_ready high after release; then input 100 -> [0]=+1, [1]=0, [2]=-1, [3]=+1, [4]=+1, rest 0.
REQ-033 Randomised back-to-back streams with random out_ready -> every result, decoded as sum of trit x 3^i plus carry, equals the input; cross-check by feeding result pairs into ternary_adder.

Source files
------------

// File: rtl/ternary_pkg.sv
// ============================================================================
// Module : ternary_pkg
// Brief  : Shared balanced-ternary trit encoding and converter FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ternary_pkg;

    // Two-bit trit code; 2'b11 is reserved and never produced by the converter.
    typedef enum logic [1:0] {
        T_ZERO    = 2'b00,
        T_POS_ONE = 2'b01,
        T_NEG_ONE = 2'b10,
        T_INVALID = 2'b11
    } trit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

endpackage

`default_nettype wire

// File: rtl/ternary_bt_digit.sv
// ============================================================================
// Module : ternary_bt_digit
// Brief  : One balanced-ternary digit step: residue -> (trit, (residue-d)/3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ternary_bt_digit
    import ternary_pkg::*;
#(
    parameter int RES_W = 17
) (
    input  logic [RES_W-1:0] residue,
    output trit_t            trit,
    output logic [RES_W-1:0] residue_next
);

    // Weight of bit i modulo 3; the top bit carries -2^(RES_W-1).
    function automatic logic [1:0] bit_weight(input int i);
        if (i == RES_W - 1) begin
            return (((RES_W - 1) % 2) == 0) ? 2'd2 : 2'd1;
        end
        return ((i % 2) == 0) ? 2'd1 : 2'd2;
    endfunction

    // Multiplicative inverse of 3 modulo 2^RES_W (...10101011b).
    function automatic logic [RES_W-1:0] inv3();
        logic [RES_W-1:0] v;
        v = '0;
        for (int i = 0; i < RES_W; i++) begin
            v[i] = (i == 0) || ((i % 2) == 1);
        end
        return v;
    endfunction

    localparam logic [RES_W-1:0] INV3 = inv3();

    logic [1:0]       w_mod;
    logic [2:0]       w_sum;
    logic [RES_W-1:0] w_sub;
    logic [RES_W-1:0] w_diff;

    always_comb begin
        w_mod = 2'd0;
        w_sum = 3'd0;
        for (int i = 0; i < RES_W; i++) begin
            if (residue[i]) begin
                w_sum = {1'b0, w_mod} + {1'b0, bit_weight(i)};
                w_mod = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            end
        end
    end

    always_comb begin
        trit  = T_ZERO;
        w_sub = '0;
        case (w_mod)
            2'd1: begin
                trit  = T_POS_ONE;
                w_sub = RES_W'(1);
            end
            2'd2: begin
                trit  = T_NEG_ONE;
                w_sub = '1;
            end
            default: begin
                trit  = T_ZERO;
                w_sub = '0;
            end
        endcase
    end

    // The difference is a multiple of 3, so the modular inverse yields the exact quotient.
    assign w_diff       = residue - w_sub;
    assign residue_next = w_diff * INV3;

endmodule

`default_nettype wire

// File: rtl/ternary_bin2bt_conv.sv
// ============================================================================
// Module : ternary_bin2bt_conv
// Brief  : Serial signed-binary to balanced-ternary converter, one trit/cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ternary_bin2bt_conv
    import ternary_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BIN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_W-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output trit_t [WIDTH-1:0]      out_trits,
    output logic                   out_ovf
);

    localparam int RES_W = BIN_W + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    conv_state_t       r_state;
    conv_state_t       w_state_next;
    logic [RES_W-1:0]  r_residue;
    logic [IDX_W-1:0]  r_index;
    trit_t [WIDTH-1:0] r_trits;
    logic              r_ovf;

    trit_t             w_trit;
    logic [RES_W-1:0]  w_residue_next;
    logic              w_last;

    ternary_bt_digit #(
        .RES_W (RES_W)
    ) u_digit (
        .residue      (r_residue),
        .trit         (w_trit),
        .residue_next (w_residue_next)
    );

    assign w_last = (r_index == IDX_W'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = CONV;
            CONV:    if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_residue <= '0;
            r_index   <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_trits[i] <= T_ZERO;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_residue <= {in_data[BIN_W-1], in_data};
                        r_index   <= '0;
                        r_ovf     <= 1'b0;
                        for (int i = 0; i < WIDTH; i++) begin
                            r_trits[i] <= T_ZERO;
                        end
                    end
                end
                CONV: begin
                    r_trits[r_index] <= w_trit;
                    r_residue        <= w_residue_next;
                    r_index          <= r_index + IDX_W'(1);
                    // Any residue left after the last trit is the out-of-range carry.
                    if (w_last) begin
                        r_ovf <= (w_residue_next != '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_trits = r_trits;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ternary_bin2bt_conv.sv
// ============================================================================
// Module : tb_ternary_bin2bt_conv
// Brief  : Self-checking bench for the binary to balanced-ternary converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ternary_bin2bt_conv;
    import ternary_pkg::*;

    localparam int WIDTH = 8;
    localparam int BIN_W = 16;
    localparam int FULL  = 6561;
    localparam int HALF  = 3280;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BIN_W-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    trit_t [WIDTH-1:0] out_trits;
    logic              out_ovf;

    int checks = 0;
    int errors = 0;
    int pat[WIDTH];

    always #5 clk = ~clk;

    ternary_bin2bt_conv #(
        .WIDTH (WIDTH),
        .BIN_W (BIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_trits (out_trits),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int trit_val(input trit_t t);
        case (t)
            T_POS_ONE: return 1;
            T_NEG_ONE: return -1;
            T_ZERO:    return 0;
            default:   return 99;
        endcase
    endfunction

    // Carry c such that v - c*3^WIDTH lies in [-HALF, HALF].
    function automatic int carry_of(input int v);
        int x;
        x = v + HALF;
        if (x >= 0) return x / FULL;
        return -((-x + FULL - 1) / FULL);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input string tag);
        int lat;
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = 16'(v);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, WIDTH + 1);
    endtask

    task automatic check_result(input int v, input string tag);
        int s, p, bad, c, t;
        s = 0; p = 1; bad = 0;
        c = carry_of(v);
        for (int i = 0; i < WIDTH; i++) begin
            t = trit_val(out_trits[i]);
            if (t == 99) bad = 1;
            else s += t * p;
            p *= 3;
        end
        check({tag, "_invalid"}, bad, 0);
        check({tag, "_ovf"}, out_ovf, (c != 0) ? 1 : 0);
        check({tag, "_value"}, s, v - c * FULL);
    endtask

    task automatic check_pattern(input string tag);
        trit_t [WIDTH-1:0] e;
        for (int i = 0; i < WIDTH; i++) begin
            e[i] = (pat[i] == 1) ? T_POS_ONE : (pat[i] == -1) ? T_NEG_ONE : T_ZERO;
        end
        check({tag, "_trits"}, out_trits, e);
    endtask

    task automatic consume(input bit random_ready, input string tag);
        trit_t [WIDTH-1:0] snap;
        logic ov;
        int n;
        bit r;
        snap = out_trits;
        ov   = out_ovf;
        n    = 0;
        while (1) begin
            r = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n > 20) r = 1'b1;
            out_ready = r;
            step();
            n++;
            if (r) break;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_trits"}, out_trits, snap);
            check({tag, "_hold_ovf"}, out_ovf, ov);
        end
        out_ready = 1'b0;
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int v;
        trit_t [WIDTH-1:0] snap;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_trits", out_trits, 0);
        rst = 1'b0;
        #1;

        // Directed values
        pat = '{0, 0, 0, 0, 0, 0, 0, 0};
        send(0, "zero");
        check_pattern("zero");
        check_result(0, "zero");
        consume(1'b0, "zero");

        pat = '{1, 0, 1, 0, 0, 0, 0, 0};
        send(10, "ten");
        check_pattern("ten");
        check_result(10, "ten");
        consume(1'b0, "ten");

        pat = '{1, 1, -1, 0, 0, 0, 0, 0};
        send(-5, "m5");
        check_pattern("m5");
        check_result(-5, "m5");
        consume(1'b0, "m5");

        pat = '{1, 1, 1, 1, 1, 1, 1, 1};
        send(3280, "max");
        check_pattern("max");
        check_result(3280, "max");
        consume(1'b0, "max");

        pat = '{-1, -1, -1, -1, -1, -1, -1, -1};
        send(3281, "maxp1");
        check_pattern("maxp1");
        check_result(3281, "maxp1");
        check("maxp1_ovf_direct", out_ovf, 1);
        consume(1'b0, "maxp1");

        send(-32768, "minint");
        check("minint_ovf_direct", out_ovf, 1);
        check_result(-32768, "minint");
        consume(1'b0, "minint");

        // Backpressure with a stray in_valid while DONE
        pat = '{1, 0, 1, 0, 0, 0, 0, 0};
        send(10, "bp");
        snap = out_trits;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            in_data  = 16'd7;
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_valid", out_valid, 1);
            check("bp_stable", out_trits, snap);
        end
        in_valid = 1'b0;
        check_pattern("bp");
        check_result(10, "bp");
        consume(1'b0, "bp");

        // Reset in the third conversion cycle
        in_valid = 1'b1;
        in_data  = 16'd1234;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_trits", out_trits, 0);
        rst = 1'b0;
        #1;
        check("midrst_release_ready", in_ready, 1);
        pat = '{1, 0, -1, 1, 1, 0, 0, 0};
        send(100, "h100");
        check_pattern("h100");
        check_result(100, "h100");
        consume(1'b0, "h100");

        // Random back-to-back stream with random backpressure
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 6560)) - HALF;
            else v = int'($urandom_range(0, 65535)) - 32768;
            send(v, "rnd");
            check_result(v, "rnd");
            consume(1'b1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
